// File: rtl/ext_bus_ctrl.sv
// External bus controller: one CPU request at a time to instruction ROM or data RAM.
// Optional access timeout abort is enabled by defining EXT_BUS_TIMEOUT_EN.
module ext_bus_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 8,
    parameter int WAIT_CYCLES    = 0,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic              i_req_space,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_req_ready,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_instr_read,
    output logic              o_data_read,
    output logic              o_data_write,
    input  logic [DATA_W-1:0] i_instr_rdata,
    input  logic [DATA_W-1:0] i_data_rdata,
    input  logic              i_mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    // The counter only needs to reach the timeout threshold, so it parks there.
    localparam logic [7:0] WAIT_C  = 8'(WAIT_CYCLES);
    localparam logic [7:0] CNT_SAT = 8'(TIMEOUT_CYCLES);

    state_t     state_q, state_d;
    logic       wr_q, space_q;
    logic [7:0] cnt_q;
    logic       accept, rom_wr, done, tmo;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        rom_wr       = 1'b0;
        done         = 1'b0;
        tmo          = 1'b0;
        o_req_ready  = 1'b0;
        o_instr_read = 1'b0;
        o_data_read  = 1'b0;
        o_data_write = 1'b0;
        unique case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    accept = 1'b1;
                    rom_wr = i_req_write && !i_req_space;
                    state_d = rom_wr ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                // ROM writes never get here, so space 0 is always a fetch.
                o_instr_read = !space_q;
                o_data_read  = space_q && !wr_q;
                o_data_write = space_q && wr_q;
                done = i_mem_ready && (cnt_q >= WAIT_C);
`ifdef EXT_BUS_TIMEOUT_EN
                tmo = !done && (cnt_q >= CNT_SAT - 8'd1);
`endif
                if (done || tmo) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_rsp_valid = (state_q == RESP);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            space_q     <= 1'b0;
            cnt_q       <= '0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q        <= i_req_write;
                space_q     <= i_req_space;
                o_mem_addr  <= i_req_addr;
                o_mem_wdata <= i_req_wdata;
                cnt_q       <= '0;
            end else if (state_q == ACCESS && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (rom_wr || tmo) begin
                o_rsp_rdata <= '0;
                o_rsp_err   <= 1'b1;
            end else if (done) begin
                o_rsp_rdata <= wr_q    ? '0 :
                               space_q ? i_data_rdata : i_instr_rdata;
                o_rsp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// Directed bench for ext_bus_ctrl: a WAIT_CYCLES=0 instance and a WAIT_CYCLES=3 instance.
// Expectations follow EXT_BUS_TIMEOUT_EN when the bench is built with it.
module tb_ext_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, b_valid;
    logic        req_write, req_space;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [15:0] instr_rdata, data_rdata;
    logic        mem_ready;

    logic        req_ready, rsp_valid, rsp_err;
    logic [15:0] rsp_rdata, mem_wdata;
    logic [7:0]  mem_addr;
    logic        instr_read, data_read, data_write;

    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [15:0] b_rsp_rdata, b_mem_wdata;
    logic [7:0]  b_mem_addr;
    logic        b_instr_read, b_data_read, b_data_write;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ext_bus_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .TIMEOUT_CYCLES(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .i_req_write(req_write),
        .i_req_space(req_space), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_req_ready(req_ready),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata),
        .o_rsp_err(rsp_err), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_instr_read(instr_read),
        .o_data_read(data_read), .o_data_write(data_write),
        .i_instr_rdata(instr_rdata), .i_data_rdata(data_rdata),
        .i_mem_ready(mem_ready)
    );

    ext_bus_ctrl #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(3), .TIMEOUT_CYCLES(15)) dut3 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(b_valid), .i_req_write(req_write),
        .i_req_space(req_space), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_req_ready(b_req_ready),
        .o_rsp_valid(b_rsp_valid), .o_rsp_rdata(b_rsp_rdata),
        .o_rsp_err(b_rsp_err), .o_mem_addr(b_mem_addr),
        .o_mem_wdata(b_mem_wdata), .o_instr_read(b_instr_read),
        .o_data_read(b_data_read), .o_data_write(b_data_write),
        .i_instr_rdata(instr_rdata), .i_data_rdata(data_rdata),
        .i_mem_ready(1'b1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic no_strobe(input string tag);
        check({tag, "_strobes"}, {29'd0, instr_read, data_read, data_write}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 0; b_valid = 0; req_write = 0; req_space = 0;
        req_addr = 8'h00; req_wdata = 16'h0000;
        instr_rdata = 16'h0000; data_rdata = 16'h0000; mem_ready = 0;
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        no_strobe("rst");
        #21 rst_n = 1'b1;
        step();

        // RAM read, zero wait states
        req_valid = 1; req_space = 1; req_write = 0; req_addr = 8'h12;
        data_rdata = 16'hBEEF; mem_ready = 1;
        step();
        req_valid = 0; req_addr = 8'h77;
        check("rd_strobe", {29'd0, instr_read, data_read, data_write}, 32'd2);
        check("rd_busy", {31'd0, req_ready}, 32'd0);
        check("rd_addr", {24'd0, mem_addr}, 32'h12);
        step();
        check("rd_valid", {31'd0, rsp_valid}, 32'd1);
        check("rd_rdata", {16'd0, rsp_rdata}, 32'hBEEF);
        check("rd_err", {31'd0, rsp_err}, 32'd0);
        no_strobe("rd_resp");
        step();
        check("rd_b2b_ready", {31'd0, req_ready}, 32'd1);
        check("rd_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check("rd_hold", {16'd0, rsp_rdata}, 32'hBEEF);

        // ROM write is rejected without touching the bus
        req_valid = 1; req_write = 1; req_space = 0; req_addr = 8'h00;
        step();
        req_valid = 0;
        check("romwr_valid", {31'd0, rsp_valid}, 32'd1);
        check("romwr_err", {31'd0, rsp_err}, 32'd1);
        no_strobe("romwr");
        step();
        check("romwr_idle", {31'd0, req_ready}, 32'd1);
        check("romwr_err_hold", {31'd0, rsp_err}, 32'd1);
        no_strobe("romwr_idle");

        // RAM write, ready arrives in the fifth access cycle
        mem_ready = 0;
        req_valid = 1; req_write = 1; req_space = 1;
        req_addr = 8'hFF; req_wdata = 16'hA5A5;
        step();
        req_valid = 0; req_wdata = 16'h0000; req_addr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("wr_strobe", {29'd0, instr_read, data_read, data_write}, 32'd1);
            check("wr_wdata", {16'd0, mem_wdata}, 32'hA5A5);
            check("wr_addr", {24'd0, mem_addr}, 32'hFF);
            check("wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
            if (i == 4) mem_ready = 1;
            step();
        end
        check("wr_valid", {31'd0, rsp_valid}, 32'd1);
        check("wr_err", {31'd0, rsp_err}, 32'd0);
        check("wr_rdata", {16'd0, rsp_rdata}, 32'd0);
        no_strobe("wr_resp");
        step();
        mem_ready = 0;

        // Memory never answers
        req_valid = 1; req_write = 0; req_space = 1; req_addr = 8'h40;
        data_rdata = 16'h5A5A;
        step();
        req_valid = 0;
`ifdef EXT_BUS_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            check("tmo_strobe", {31'd0, data_read}, 32'd1);
            check("tmo_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        check("tmo_valid", {31'd0, rsp_valid}, 32'd1);
        check("tmo_err", {31'd0, rsp_err}, 32'd1);
        check("tmo_rdata", {16'd0, rsp_rdata}, 32'd0);
        no_strobe("tmo_resp");
        step();
`else
        for (int i = 0; i < 100; i++) begin
            check("hang_strobe", {31'd0, data_read}, 32'd1);
            check("hang_no_rsp", {31'd0, rsp_valid}, 32'd0);
            step();
        end
        mem_ready = 1;
        step();
        check("late_valid", {31'd0, rsp_valid}, 32'd1);
        check("late_rdata", {16'd0, rsp_rdata}, 32'h5A5A);
        check("late_err", {31'd0, rsp_err}, 32'd0);
        step();
        mem_ready = 0;
`endif

        // ROM read on the three-wait-state instance
        b_valid = 1; req_write = 0; req_space = 0; req_addr = 8'h05;
        instr_rdata = 16'h1234;
        step();
        b_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check("w3_strobe", {29'd0, b_instr_read, b_data_read, b_data_write}, 32'd4);
            check("w3_no_rsp", {31'd0, b_rsp_valid}, 32'd0);
            step();
        end
        check("w3_valid", {31'd0, b_rsp_valid}, 32'd1);
        check("w3_rdata", {16'd0, b_rsp_rdata}, 32'h1234);
        check("w3_err", {31'd0, b_rsp_err}, 32'd0);
        check("w3_strobe_off", {31'd0, b_instr_read}, 32'd0);
        step();
        check("w3_ready", {31'd0, b_req_ready}, 32'd1);

        // Reset lands in the second access cycle
        req_valid = 1; req_space = 0; req_addr = 8'h33; mem_ready = 0;
        step();
        req_valid = 0;
        step();
        check("ra_strobe", {31'd0, instr_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        no_strobe("ra_async");
        check("ra_ready", {31'd0, req_ready}, 32'd1);
        check("ra_addr", {24'd0, mem_addr}, 32'd0);
        check("ra_rdata", {16'd0, rsp_rdata}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("ra_no_rsp", {31'd0, rsp_valid}, 32'd0);
            no_strobe("ra_held");
        end
        rst_n = 1'b1;
        step();
        check("ra_rel_ready", {31'd0, req_ready}, 32'd1);
        check("ra_rel_no_rsp", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1; req_space = 0; req_addr = 8'h05; mem_ready = 1;
        step();
        req_valid = 0;
        check("ra_rd_strobe", {29'd0, instr_read, data_read, data_write}, 32'd4);
        check("ra_rd_addr", {24'd0, mem_addr}, 32'h05);
        step();
        check("ra_rd_valid", {31'd0, rsp_valid}, 32'd1);
        check("ra_rd_rdata", {16'd0, rsp_rdata}, 32'h1234);
        check("ra_rd_err", {31'd0, rsp_err}, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
